// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: bundle bit positions,
// the bubble mask and the issue FSM states.
package ctrl_pkg;

    localparam int BUNDLE_W = 26;
    localparam int DEST_W   = 5;

    localparam int NOP_STALL_BIT = 25;
    localparam int PC_ENABLE_BIT = 24;
    localparam int DMEM_WE_BIT   = 3;
    localparam int DMEM_RE_BIT   = 2;
    localparam int RF_WE_BIT     = 0;

    // Bits that must be cleared so a bubble has no architectural effect.
    localparam logic [BUNDLE_W-1:0] BUBBLE_MASK =
        (BUNDLE_W'(1) << NOP_STALL_BIT) |
        (BUNDLE_W'(1) << DMEM_WE_BIT)   |
        (BUNDLE_W'(1) << DMEM_RE_BIT)   |
        (BUNDLE_W'(1) << RF_WE_BIT);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: bundle, destination and valid move together.
// hold=1 freezes the stage; reset is asynchronous active-low.
module ctrl_stage_reg
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic [BUNDLE_W-1:0] bundle_d,
    input  logic [DEST_W-1:0]   dest_d,
    input  logic                valid_d,
    output logic [BUNDLE_W-1:0] bundle_q,
    output logic [DEST_W-1:0]   dest_q,
    output logic                valid_q
);

    // Capture the upstream slot unless the pipe is frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bundle_q <= '0;
            dest_q   <= '0;
            valid_q  <= 1'b0;
        end else if (!hold) begin
            bundle_q <= bundle_d;
            dest_q   <= dest_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with flush kill window and memory freeze.
// Optional counters (retired_out, bubble_out) under CTRL_PIPE_PERF_EN.
module ctrl_pipe
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [BUNDLE_W-1:0] bundle_in,
    input  logic [DEST_W-1:0]   dest_in,
    input  logic                flush_in,
    input  logic                mem_busy_in,
    output logic [BUNDLE_W-1:0] ex_bundle_out,
    output logic [BUNDLE_W-1:0] mem_bundle_out,
    output logic [BUNDLE_W-1:0] wb_bundle_out,
    output logic [DEST_W-1:0]   ex_dest_out,
    output logic [DEST_W-1:0]   mem_dest_out,
    output logic [DEST_W-1:0]   wb_dest_out,
    output logic                ex_valid_out,
    output logic                mem_valid_out,
    output logic                wb_valid_out,
    output logic                pc_enable_out
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]         retired_out,
    output logic [15:0]         bubble_out
`endif
);

    state_t              state_q;
    state_t              state_d;
    logic                advance;
    logic                kill;
    logic [BUNDLE_W-1:0] issue_bundle;
    logic [DEST_W-1:0]   issue_dest;
    logic                issue_valid;

    assign advance = !mem_busy_in;

    assign pc_enable_out = bundle_in[PC_ENABLE_BIT]
                         & !mem_busy_in
                         & !bundle_in[NOP_STALL_BIT];

    // A flush request, a decoder stall and the trailing FLUSH slot all
    // collapse into one bubble for this issue slot.
    always_comb begin
        kill = flush_in
             | bundle_in[NOP_STALL_BIT]
             | (state_q == FLUSH);
        issue_bundle = bundle_in;
        issue_dest   = dest_in;
        issue_valid  = 1'b1;
        if (kill) begin
            issue_bundle = bundle_in & ~BUBBLE_MASK;
            issue_dest   = '0;
            issue_valid  = 1'b0;
        end
    end

    // Next FSM state; FLUSH lasts while flush_in keeps arriving.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush_in)  state_d = FLUSH;
            FLUSH:   if (!flush_in) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM register, frozen with the rest of the pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else if (advance) begin
            state_q <= state_d;
        end
    end

    ctrl_stage_reg u_ex (
        .clk      (clk),
        .reset    (reset),
        .hold     (mem_busy_in),
        .bundle_d (issue_bundle),
        .dest_d   (issue_dest),
        .valid_d  (issue_valid),
        .bundle_q (ex_bundle_out),
        .dest_q   (ex_dest_out),
        .valid_q  (ex_valid_out)
    );

    ctrl_stage_reg u_mem (
        .clk      (clk),
        .reset    (reset),
        .hold     (mem_busy_in),
        .bundle_d (ex_bundle_out),
        .dest_d   (ex_dest_out),
        .valid_d  (ex_valid_out),
        .bundle_q (mem_bundle_out),
        .dest_q   (mem_dest_out),
        .valid_q  (mem_valid_out)
    );

    ctrl_stage_reg u_wb (
        .clk      (clk),
        .reset    (reset),
        .hold     (mem_busy_in),
        .bundle_d (mem_bundle_out),
        .dest_d   (mem_dest_out),
        .valid_d  (mem_valid_out),
        .bundle_q (wb_bundle_out),
        .dest_q   (wb_dest_out),
        .valid_q  (wb_valid_out)
    );

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] retired_q;
    logic [15:0] bubble_q;

    // Retire on leaving WB; bubble count saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
            bubble_q  <= '0;
        end else if (advance) begin
            if (wb_valid_out) begin
                retired_q <= retired_q + 32'd1;
            end
            if (kill && bubble_q != 16'hFFFF) begin
                bubble_q <= bubble_q + 16'd1;
            end
        end
    end

    assign retired_out = retired_q;
    assign bubble_out  = bubble_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; counter checks only when
// CTRL_PIPE_PERF_EN is defined.
module tb_ctrl_pipe;

    logic        clk;
    logic        reset;
    logic [25:0] bundle_in;
    logic [4:0]  dest_in;
    logic        flush_in;
    logic        mem_busy_in;
    logic [25:0] ex_bundle_out;
    logic [25:0] mem_bundle_out;
    logic [25:0] wb_bundle_out;
    logic [4:0]  ex_dest_out;
    logic [4:0]  mem_dest_out;
    logic [4:0]  wb_dest_out;
    logic        ex_valid_out;
    logic        mem_valid_out;
    logic        wb_valid_out;
    logic        pc_enable_out;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] retired_out;
    logic [15:0] bubble_out;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [25:0] B   = 26'h100000F;
    localparam logic [25:0] BM  = 26'h1000002;
    localparam logic [25:0] BNS = 26'h300000F;

    ctrl_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .bundle_in      (bundle_in),
        .dest_in        (dest_in),
        .flush_in       (flush_in),
        .mem_busy_in    (mem_busy_in),
        .ex_bundle_out  (ex_bundle_out),
        .mem_bundle_out (mem_bundle_out),
        .wb_bundle_out  (wb_bundle_out),
        .ex_dest_out    (ex_dest_out),
        .mem_dest_out   (mem_dest_out),
        .wb_dest_out    (wb_dest_out),
        .ex_valid_out   (ex_valid_out),
        .mem_valid_out  (mem_valid_out),
        .wb_valid_out   (wb_valid_out),
        .pc_enable_out  (pc_enable_out)
`ifdef CTRL_PIPE_PERF_EN
        ,
        .retired_out    (retired_out),
        .bubble_out     (bubble_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [25:0] b, input logic [4:0] d,
                         input logic f);
        bundle_in = b;
        dest_in   = d;
        flush_in  = f;
    endtask

    initial begin
        reset       = 1'b0;
        mem_busy_in = 1'b0;
        drive(26'h1000000, 5'd0, 1'b0);
        tick();
        tick();
        check("rst_ex_bundle", 32'(ex_bundle_out), 32'h0);
        check("rst_ex_valid", 32'(ex_valid_out), 32'h0);
        check("rst_mem_valid", 32'(mem_valid_out), 32'h0);
        check("rst_wb_dest", 32'(wb_dest_out), 32'h0);
        check("rst_pc_en", 32'(pc_enable_out), 32'h1);
`ifdef CTRL_PIPE_PERF_EN
        check("rst_retired", retired_out, 32'h0);
        check("rst_bubble", 32'(bubble_out), 32'h0);
`endif

        // Single instruction walks EX -> MEM -> WB.
        reset = 1'b1;
        drive(26'h0000001, 5'd8, 1'b0);
        tick();
        check("lat_ex_valid", 32'(ex_valid_out), 32'h1);
        check("lat_ex_dest", 32'(ex_dest_out), 32'd8);
        check("lat_mem_empty", 32'(mem_valid_out), 32'h0);
        drive(26'h0, 5'd0, 1'b0);
        tick();
        check("lat_mem_dest", 32'(mem_dest_out), 32'd8);
        check("lat_mem_valid", 32'(mem_valid_out), 32'h1);
        check("lat_wb_empty", 32'(wb_valid_out), 32'h0);
        tick();
        check("lat_wb_dest", 32'(wb_dest_out), 32'd8);
        check("lat_wb_valid", 32'(wb_valid_out), 32'h1);
        check("lat_wb_bundle", 32'(wb_bundle_out), 32'h1);
`ifdef CTRL_PIPE_PERF_EN
        check("lat_retired0", retired_out, 32'd0);
`endif
        tick();
`ifdef CTRL_PIPE_PERF_EN
        check("lat_retired1", retired_out, 32'd1);
`endif

        // One-cycle flush kills exactly two issue slots.
        drive(B, 5'd10, 1'b0);
        tick();
        drive(B, 5'd11, 1'b1);
        tick();
        check("fl1_ex_valid", 32'(ex_valid_out), 32'h0);
        check("fl1_ex_bundle", 32'(ex_bundle_out), 32'(BM));
        check("fl1_ex_dest", 32'(ex_dest_out), 32'h0);
        check("fl1_mem_kept", 32'(mem_dest_out), 32'd10);
        check("fl1_mem_valid", 32'(mem_valid_out), 32'h1);
        drive(B, 5'd12, 1'b0);
        tick();
        check("fl2_ex_valid", 32'(ex_valid_out), 32'h0);
        check("fl2_ex_bundle", 32'(ex_bundle_out), 32'(BM));
        drive(B, 5'd13, 1'b0);
        tick();
        check("fl3_ex_valid", 32'(ex_valid_out), 32'h1);
        check("fl3_ex_dest", 32'(ex_dest_out), 32'd13);
        check("fl3_ex_bundle", 32'(ex_bundle_out), 32'(B));
`ifdef CTRL_PIPE_PERF_EN
        check("fl_bubbles", 32'(bubble_out), 32'd2);
`endif

        // Three-cycle freeze with a full pipe.
        drive(B, 5'd14, 1'b0);
        tick();
        drive(B, 5'd15, 1'b0);
        tick();
        mem_busy_in = 1'b1;
        drive(B, 5'd16, 1'b0);
        #1;
        check("frz_pc_en", 32'(pc_enable_out), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_ex_dest", 32'(ex_dest_out), 32'd15);
            check("frz_mem_dest", 32'(mem_dest_out), 32'd14);
            check("frz_wb_dest", 32'(wb_dest_out), 32'd13);
        end
        mem_busy_in = 1'b0;
        #1;
        check("frz_pc_en_back", 32'(pc_enable_out), 32'h1);
        tick();
        check("res_ex_dest", 32'(ex_dest_out), 32'd16);
        check("res_mem_dest", 32'(mem_dest_out), 32'd15);
        check("res_wb_dest", 32'(wb_dest_out), 32'd14);

        // Stall plus flush together: two bubbles, not three.
        drive(BNS, 5'd17, 1'b1);
        #1;
        check("ns_pc_en", 32'(pc_enable_out), 32'h0);
        tick();
        check("ns1_ex_valid", 32'(ex_valid_out), 32'h0);
        check("ns1_ex_bundle", 32'(ex_bundle_out), 32'(BM));
        drive(B, 5'd18, 1'b0);
        tick();
        check("ns2_ex_valid", 32'(ex_valid_out), 32'h0);
        drive(B, 5'd19, 1'b0);
        tick();
        check("ns3_ex_dest", 32'(ex_dest_out), 32'd19);
        check("ns3_ex_valid", 32'(ex_valid_out), 32'h1);
`ifdef CTRL_PIPE_PERF_EN
        check("ns_bubbles", 32'(bubble_out), 32'd4);
        force dut.bubble_q = 16'hFFFE;
        #1;
        release dut.bubble_q;
`endif

        // Two-cycle flush extends the kill window to three slots.
        drive(B, 5'd22, 1'b1);
        tick();
        drive(B, 5'd23, 1'b1);
        tick();
        check("ext2_ex_valid", 32'(ex_valid_out), 32'h0);
        drive(B, 5'd24, 1'b0);
        tick();
        check("ext3_ex_valid", 32'(ex_valid_out), 32'h0);
`ifdef CTRL_PIPE_PERF_EN
        check("sat_bubble", 32'(bubble_out), 32'hFFFF);
`endif
        drive(B, 5'd25, 1'b0);
        tick();
        check("ext4_ex_dest", 32'(ex_dest_out), 32'd25);
`ifdef CTRL_PIPE_PERF_EN
        check("sat_hold", 32'(bubble_out), 32'hFFFF);
`endif

        // Asynchronous reset during FLUSH with the pipe frozen.
        drive(B, 5'd26, 1'b1);
        tick();
        mem_busy_in = 1'b1;
        drive(B, 5'd26, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_ex_valid", 32'(ex_valid_out), 32'h0);
        check("arst_ex_bundle", 32'(ex_bundle_out), 32'h0);
        check("arst_mem_dest", 32'(mem_dest_out), 32'h0);
        check("arst_wb_valid", 32'(wb_valid_out), 32'h0);
        check("arst_wb_bundle", 32'(wb_bundle_out), 32'h0);
`ifdef CTRL_PIPE_PERF_EN
        check("arst_retired", retired_out, 32'h0);
        check("arst_bubble", 32'(bubble_out), 32'h0);
`endif
        tick();
        reset = 1'b1;
        mem_busy_in = 1'b0;
        drive(B, 5'd27, 1'b0);
        tick();
        check("post_ex_valid", 32'(ex_valid_out), 32'h1);
        check("post_ex_dest", 32'(ex_dest_out), 32'd27);
        check("post_mem_valid", 32'(mem_valid_out), 32'h0);
`ifdef CTRL_PIPE_PERF_EN
        check("post_bubble", 32'(bubble_out), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
